// File: rtl/inst_rom_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_rom_loader_if
//  Purpose  : Instruction-fetch and boot-load signal bundle for inst_rom_loader.
//  Revision : 1.0  initial release
// ============================================================================
interface inst_rom_loader_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  i_chipEnable;
    logic [31:0]           i_romAddr;
    logic [31:0]           o_romInst;
    logic [7:0]            i_loadByte;
    logic                  i_loadValid;
    logic                  i_loadLast;
    logic                  o_loadReady;
    logic                  o_cpuRun;
    logic                  o_loadError;
    logic [DEPTH_LOG2:0]   o_wordCount;

    modport slave (
        input  i_chipEnable, i_romAddr, i_loadByte, i_loadValid, i_loadLast,
        output o_romInst, o_loadReady, o_cpuRun, o_loadError, o_wordCount
    );

    modport master (
        output i_chipEnable, i_romAddr, i_loadByte, i_loadValid, i_loadLast,
        input  o_romInst, o_loadReady, o_cpuRun, o_loadError, o_wordCount
    );
endinterface
`default_nettype wire

// File: rtl/inst_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : inst_rom_loader
//  Purpose  : Boot-loadable instruction store; big-endian byte loader plus
//             zero-latency fetch port, CPU held in reset until load completes.
//  Revision : 1.0  initial release
// ============================================================================
module inst_rom_loader #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    inst_rom_loader_if.slave     bus
);
    localparam int                  c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL  = (DEPTH_LOG2 + 1)'(c_DEPTH);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [31:0]             shift_q, shift_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    error_q, error_d;

    logic [31:0]             mem_q [c_DEPTH];

    logic                    w_accept;
    logic                    w_we;
    logic [31:0]             w_word;
    logic [DEPTH_LOG2-1:0]   w_waddr;
    logic [DEPTH_LOG2-1:0]   w_index;
    logic                    w_hit;
    logic [1:0]              w_unused_addr_bits;

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        shift_d  = shift_q;
        count_d  = count_q;
        error_d  = error_q;
        w_we     = 1'b0;
        w_accept = (state_q == S_LOAD) && bus.i_loadValid;
        // Shift register only ever holds already-received lanes; the rest stay zero.
        w_word   = shift_q | ({bus.i_loadByte, 24'h00_0000} >> {lane_q, 3'b000});

        if (w_accept) begin
            if ((lane_q == 2'd3) || bus.i_loadLast) begin
                if (count_q == c_FULL) begin
                    error_d = 1'b1;
                end else begin
                    w_we    = 1'b1;
                    count_d = count_q + 1'b1;
                end
                lane_d  = 2'd0;
                shift_d = 32'h0000_0000;
            end else begin
                lane_d  = lane_q + 2'd1;
                shift_d = w_word;
            end
            if (bus.i_loadLast) begin
                state_d = S_RUN;
            end
        end
    end

    assign w_waddr = count_q[DEPTH_LOG2-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
            lane_q  <= 2'd0;
            shift_q <= 32'h0000_0000;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            shift_q <= shift_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    // Contents survive reset; the word-count gate on the read side hides stale data.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[w_waddr] <= w_word;
        end
    end

    assign w_index = bus.i_romAddr[DEPTH_LOG2+1:2];
    assign w_hit   = bus.i_chipEnable
                   && (state_q == S_RUN)
                   && ({1'b0, w_index} < count_q)
                   && (bus.i_romAddr[31:DEPTH_LOG2+2] == '0);

    assign w_unused_addr_bits = bus.i_romAddr[1:0];

    assign bus.o_romInst   = w_hit ? mem_q[w_index] : NOP_WORD;
    assign bus.o_loadReady = (state_q == S_LOAD);
    assign bus.o_cpuRun    = (state_q == S_RUN);
    assign bus.o_loadError = error_q;
    assign bus.o_wordCount = count_q;

endmodule
`default_nettype wire

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Responder end of the CPU instruction-fetch port. Answers chipEnable/romAddr with the instruction word on romInst.
- Backed by an internal word array. The array is filled after reset from a byte-stream boot-load port.
- Holds the CPU core in reset (cpuRun low) until loading completes. Sits beside the CPU top, replacing a fixed ROM.

Parameters:
- DEPTH_LOG2, 10, log2 of array depth in 32-bit words (default 1024 words).
- NOP_WORD, 32'h00000000, value returned for disabled, unloaded or out-of-range fetches.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous assert, active-low
- i_chipEnable  in  1  fetch enable from CPU
- i_romAddr  in  32  fetch byte address from CPU
- o_romInst  out  32  instruction word to CPU
- i_loadByte  in  8  boot-load data byte
- i_loadValid  in  1  byte valid
- i_loadLast  in  1  qualifies the final byte of the image (sampled with valid)
- o_loadReady  out  1  loader accepts bytes
- o_cpuRun  out  1  high = CPU may leave reset and fetch
- o_loadError  out  1  sticky: image exceeded array capacity
- o_wordCount  out  DEPTH_LOG2+1  number of words written

Behaviour:
- Reset (rst=0, async) forces the following:
  - state=LOAD, lane=0, shift register=0.
  - o_wordCount=0, o_cpuRun=0, o_loadError=0, o_loadReady=1.
  - Array contents are not cleared. They are invisible because of the wordCount gating below.
- States:
  - LOAD: o_loadReady=1. A byte is accepted on a rising edge with i_loadValid=1.
  - RUN: o_loadReady=0. i_loadValid, i_loadByte and i_loadLast are ignored. The block stays in RUN until reset.
- Assembly is big-endian:
  - Lane 0 byte goes to bits[31:24], lane 3 byte goes to bits[7:0].
  - lane increments per accepted byte and wraps 3->0.
- Word write happens on the same edge as the accepted byte when lane==3 or i_loadLast=1:
  - array[wordCount] <= assembled word. Lanes not yet received are zero-filled.
  - wordCount increments. lane resets to 0.
- Last byte: the accepting edge moves state to RUN. o_cpuRun is 1 from the next cycle, i.e. 1 cycle after the last-byte edge.
- Overflow: a word write requested when wordCount == 2^DEPTH_LOG2 is dropped.
  - wordCount saturates. o_loadError is set and stays sticky until reset.
  - Bytes continue to be accepted until last.
- Fetch (combinational, zero-cycle latency, matching the CPU single-cycle fetch):
  - index = i_romAddr[DEPTH_LOG2+1:2]. Bits [1:0] are ignored.
  - o_romInst = array[index] when i_chipEnable=1, o_cpuRun=1, index < wordCount, and i_romAddr[31:DEPTH_LOG2+2]==0.
  - Otherwise o_romInst = NOP_WORD.
- Timing edge cases:
  - A fetch in the same cycle as the last-byte write returns NOP_WORD, because o_cpuRun is still 0.
  - i_loadLast with i_loadValid=0 has no effect.
- Reset mid-load discards the partial word and count. The next byte after reset is lane 0 of word 0.
- Implementation: the array is a register array with a single write port and a single async read port.

Test Plan:
- Load bytes 34 01 00 10 / 00 00 00 08 (last on 8th) -> o_cpuRun=1 one cycle after 8th edge, o_wordCount=2. Fetch 0x0 -> 0x34010010, 0x4 -> 0x00000008, 0x8 -> 0x00000000.
- Partial image AA BB CC DD 11 22 (last on 22) -> o_wordCount=2, fetch 0x4 -> 0x11220000, fetch 0x6 -> 0x11220000 (low bits ignored).
- DEPTH_LOG2=2, load 20 bytes -> o_loadError=1, o_wordCount=4, fetch 0xC -> word 3, fetch 0x10 -> 0x00000000 (upper address bits nonzero).
- After a valid load, i_chipEnable=0 with addr 0x0 -> o_romInst=0x00000000. Toggle i_loadValid in RUN -> o_wordCount and array unchanged, o_loadReady=0.
- Load 3 bytes, pull rst low mid-cycle -> o_cpuRun/o_wordCount/lane cleared immediately (async). Reload 4 bytes 01 02 03 04 last -> fetch 0x0 -> 0x01020304.
- Fetch addr 0x0 on the same cycle as the last-byte edge -> 0x00000000. Next cycle -> loaded word.
